// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: opcodes, state
// encodings and the select codes driven onto the datapath muxes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_IN   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_IMM = 2'd1;
    localparam logic [1:0] WSEL_MEM = 2'd2;
    localparam logic [1:0] WSEL_IN  = 2'd3;

    localparam logic PC_INC    = 1'b0;
    localparam logic PC_BRANCH = 1'b1;

    // Opcodes 0x0-0x7 are the eight ALU functions.
    function automatic logic is_alu(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; expired flags the
// LIMIT-th consecutive waiting cycle. LIMIT = 0 disables the timeout.
module ctrl_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int TW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam int LAST = (LIMIT > 0) ? LIMIT - 1 : 0;

    logic [TW-1:0] value;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            value <= '0;
        end else if (count) begin
            value <= value + TW'(1);
        end
    end

    assign expired = (LIMIT != 0) && (value == LAST[TW-1:0]);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: fetch, decode, execute and memory phases, with a
// retired-instruction counter and a sticky fault on memory timeout.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ack,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_ld,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic [2:0]       alu_op,
    output logic             flags_ld,
    output logic             in_ack,
    output logic             out_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_next;
    logic   retire;
    logic   timeout;
    logic   waiting;
    logic   expired;

    assign waiting = (state == S_FETCH) || (state == S_MEM);

    // One timer serves both FETCH and MEM; it restarts whenever an ack lands
    // or the FSM is not waiting, so it is zero on entry to either state.
    ctrl_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting || mem_ack),
        .count  (waiting && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            instr_count <= '0;
            fault       <= 1'b0;
        end else begin
            state <= state_next;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (timeout) begin
                fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_next = S_DECODE;
                end else if (expired) begin
                    state_next = S_HALT;
                    timeout    = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_LD || opcode == OP_ST) state_next = S_MEM;
                else if (opcode == OP_HALT)             state_next = S_HALT;
                else                                    state_next = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_IN:   retire = in_valid;
                    OP_OUT:  retire = out_ready;
                    default: retire = 1'b1;
                endcase
                if (retire) state_next = S_FETCH;
            end
            S_MEM: begin
                if (mem_ack) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (expired) begin
                    state_next = S_HALT;
                    timeout    = 1'b1;
                end
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_ld     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = PC_INC;
        rf_we     = 1'b0;
        rf_wsel   = WSEL_ALU;
        alu_op    = 3'd0;
        flags_ld  = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_ld = 1'b1;
                    pc_en = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_alu(opcode)) begin
                    rf_we    = 1'b1;
                    rf_wsel  = WSEL_ALU;
                    alu_op   = opcode[2:0];
                    flags_ld = 1'b1;
                end else begin
                    case (opcode)
                        OP_LDI: begin
                            rf_we   = 1'b1;
                            rf_wsel = WSEL_IMM;
                        end
                        OP_BR: begin
                            pc_en  = 1'b1;
                            pc_sel = PC_BRANCH;
                        end
                        OP_BZ: begin
                            if (zero_flag) begin
                                pc_en  = 1'b1;
                                pc_sel = PC_BRANCH;
                            end
                        end
                        OP_IN: begin
                            if (in_valid) begin
                                rf_we   = 1'b1;
                                rf_wsel = WSEL_IN;
                                in_ack  = 1'b1;
                            end
                        end
                        OP_OUT: out_valid = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_ST);
                if (mem_ack && opcode == OP_LD) begin
                    rf_we   = 1'b1;
                    rf_wsel = WSEL_MEM;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomised and directed bench for cpu_control_fsm, checked every cycle
// against an instruction-level reference model.
module tb_cpu_control_fsm;

    localparam int CNT_W       = 6;
    localparam int MEM_TIMEOUT = 15;

    localparam int PH_IDLE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_EXEC   = 3;
    localparam int PH_MEM    = 4;
    localparam int PH_HALT   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic             zero_flag = 1'b0;
    logic             mem_ack = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             mem_req, mem_we, addr_sel, ir_ld, pc_en, pc_sel, rf_we;
    logic [1:0]       rf_wsel;
    logic [2:0]       alu_op;
    logic             flags_ld, in_ack, out_valid, halted, fault;
    logic [CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    cpu_control_fsm #(
        .CNT_W(CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .zero_flag(zero_flag), .mem_ack(mem_ack), .in_valid(in_valid),
        .out_ready(out_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_ld(ir_ld), .pc_en(pc_en), .pc_sel(pc_sel),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_op(alu_op), .flags_ld(flags_ld),
        .in_ack(in_ack), .out_valid(out_valid), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         m_phase = PH_IDLE;
    int         m_wait = 0;
    int         m_count = 0;
    bit         m_fault = 1'b0;
    logic [3:0] m_ir = 4'h0;
    logic [3:0] prog[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Directed programs come from the queue; afterwards instructions are random.
    function automatic logic [3:0] next_instr();
        logic [3:0] r;
        if (prog.size() > 0) return prog.pop_front();
        if ($urandom_range(0, 39) == 0) return 4'hF;
        r = 4'($urandom_range(0, 14));
        return r;
    endfunction

    task automatic checkOutput();
        logic e_req, e_we, e_asel, e_irld, e_pcen, e_pcsel, e_rfwe;
        logic e_flags, e_inack, e_outv, e_halt;
        logic [1:0] e_wsel;
        logic [2:0] e_alu;
        logic [15:0] exp_vec, act_vec;
        {e_req, e_we, e_asel, e_irld, e_pcen, e_pcsel, e_rfwe} = '0;
        {e_flags, e_inack, e_outv, e_halt} = '0;
        e_wsel = 2'd0;
        e_alu  = 3'd0;
        if (m_phase == PH_FETCH) begin
            e_req = 1'b1;
            if (mem_ack) begin
                e_irld = 1'b1;
                e_pcen = 1'b1;
            end
        end else if (m_phase == PH_EXEC) begin
            if (m_ir < 4'h8) begin
                e_rfwe = 1'b1; e_alu = m_ir[2:0]; e_flags = 1'b1;
            end else if (m_ir == 4'h8) begin
                e_rfwe = 1'b1; e_wsel = 2'd1;
            end else if (m_ir == 4'hC || (m_ir == 4'hB && zero_flag)) begin
                e_pcen = 1'b1; e_pcsel = 1'b1;
            end else if (m_ir == 4'hD && in_valid) begin
                e_rfwe = 1'b1; e_wsel = 2'd3; e_inack = 1'b1;
            end else if (m_ir == 4'hE) begin
                e_outv = 1'b1;
            end
        end else if (m_phase == PH_MEM) begin
            e_req = 1'b1;
            e_asel = 1'b1;
            e_we = (m_ir == 4'hA);
            if (mem_ack && m_ir == 4'h9) begin
                e_rfwe = 1'b1; e_wsel = 2'd2;
            end
        end else if (m_phase == PH_HALT) begin
            e_halt = 1'b1;
        end
        exp_vec = {e_req, e_we, e_asel, e_irld, e_pcen, e_pcsel, e_rfwe, e_wsel,
                   e_alu, e_flags, e_inack, e_outv, e_halt};
        act_vec = {mem_req, mem_we, addr_sel, ir_ld, pc_en, pc_sel, rf_we, rf_wsel,
                   alu_op, flags_ld, in_ack, out_valid, halted};
        check("strobes", int'(act_vec), int'(exp_vec));
        check("fault", int'(fault), int'(m_fault));
        check("instr_count", int'(instr_count), m_count);
    endtask

    // Advance the reference model by one clock using the inputs of this cycle.
    task automatic modelUpdate();
        bit done;
        done = 1'b0;
        if (!rst) begin
            m_phase = PH_IDLE; m_wait = 0; m_count = 0; m_fault = 1'b0;
            return;
        end
        case (m_phase)
            PH_IDLE: if (start) begin m_phase = PH_FETCH; m_wait = 0; end
            PH_FETCH: begin
                if (mem_ack) begin
                    m_phase = PH_DECODE;
                    m_ir = next_instr();
                end else begin
                    m_wait++;
                    if (MEM_TIMEOUT != 0 && m_wait == MEM_TIMEOUT) begin
                        m_phase = PH_HALT; m_fault = 1'b1;
                    end
                end
            end
            PH_DECODE: begin
                if (m_ir == 4'h9 || m_ir == 4'hA) begin m_phase = PH_MEM; m_wait = 0; end
                else if (m_ir == 4'hF) m_phase = PH_HALT;
                else m_phase = PH_EXEC;
            end
            PH_EXEC: done = (m_ir == 4'hD) ? in_valid : (m_ir == 4'hE) ? out_ready : 1'b1;
            PH_MEM: begin
                if (mem_ack) done = 1'b1;
                else begin
                    m_wait++;
                    if (MEM_TIMEOUT != 0 && m_wait == MEM_TIMEOUT) begin
                        m_phase = PH_HALT; m_fault = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (done) begin
            m_count = (m_count + 1) % (1 << CNT_W);
            m_phase = PH_FETCH;
            m_wait = 0;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit ack,
                                 input bit iv, input bit ordy, input bit z);
        @(negedge clk);
        rst = r; start = s; mem_ack = ack; in_valid = iv; out_ready = ordy;
        zero_flag = z; opcode = m_ir;
        #1;
        checkOutput();
        modelUpdate();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        m_phase = PH_IDLE; m_wait = 0; m_count = 0; m_fault = 1'b0;
        prog.delete();
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // LDI, ADD, HALT with zero-wait memory
        doReset();
        prog = '{4'h8, 4'h0, 4'hF};
        applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        afterEdge(); check("t1_cnt_before", int'(instr_count), 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        afterEdge(); check("t1_retire_c3", int'(instr_count), 1);
        repeat (3) applyStimulus(1, 0, 1, 0, 0, 0);
        afterEdge(); check("t1_retire_c6", int'(instr_count), 2);
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        afterEdge();
        check("t1_halted", int'(halted), 1);
        check("t1_fault", int'(fault), 0);
        check("t1_count", int'(instr_count), 2);

        // BZ taken then not taken
        doReset();
        prog = '{4'hB, 4'hB, 4'hF};
        applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 1);
        check("t2_bz_taken_pc_en", int'(pc_en), 1);
        check("t2_bz_taken_pc_sel", int'(pc_sel), 1);
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        check("t2_bz_not_taken_pc_en", int'(pc_en), 0);
        afterEdge(); check("t2_count", int'(instr_count), 2);

        // LD with ack four cycles late
        doReset();
        prog = '{4'h9, 4'hF};
        applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, (i == 4), 0, 0, 0);
            check("t3_mem_req", int'(mem_req), 1);
            check("t3_addr_sel", int'(addr_sel), 1);
            check("t3_rf_we", int'(rf_we), (i == 4) ? 1 : 0);
            if (i == 4) check("t3_rf_wsel", int'(rf_wsel), 2);
        end

        // Memory never answers: timeout after 15 waiting cycles
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        repeat (14) applyStimulus(1, 0, 0, 0, 0, 0);
        afterEdge(); check("t4_not_yet_halted", int'(halted), 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        afterEdge();
        check("t4_halted", int'(halted), 1);
        check("t4_fault", int'(fault), 1);
        check("t4_mem_req_low", int'(mem_req), 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        afterEdge(); check("t4_start_ignored", int'(halted), 1);

        // OUT with slow consumer, then IN with late data
        doReset();
        prog = '{4'hE, 4'hD, 4'hF};
        applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 0, (i == 3), 0);
            check("t5_out_valid", int'(out_valid), 1);
        end
        repeat (2) applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, (i == 2), 0, 0);
            check("t5_in_ack", int'(in_ack), (i == 2) ? 1 : 0);
            check("t5_rf_we", int'(rf_we), (i == 2) ? 1 : 0);
        end

        // Reset in the middle of a MEM wait
        doReset();
        prog = '{4'h0, 4'hA};
        applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (5) applyStimulus(1, 0, 1, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
        check("t6_count_before", int'(instr_count), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        afterEdge();
        check("t6_mem_req", int'(mem_req), 0);
        check("t6_count", int'(instr_count), 0);

        // Counter wrap from all-ones back to zero
        doReset();
        for (int i = 0; i < 64; i++) prog.push_back(4'($urandom_range(0, 7)));
        applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (63 * 3) applyStimulus(1, 0, 1, 0, 0, 0);
        afterEdge(); check("t6_all_ones", int'(instr_count), (1 << CNT_W) - 1);
        repeat (3) applyStimulus(1, 0, 1, 0, 0, 0);
        afterEdge(); check("t6_wrap", int'(instr_count), 0);

        // Random traffic; run 3 starves memory so timeouts appear
        for (int run = 0; run < 6; run++) begin
            doReset();
            for (int c = 0; c < 400; c++) begin
                applyStimulus(($urandom_range(0, 99) != 0),
                              ($urandom_range(0, 3) == 0),
                              (run == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0),
                              1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
